// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg -- shared constants for the reg_pipe register pipeline.
//
// Contents:
//   DEFAULT_WIDTH  default data bits per word
//   DEFAULT_DEPTH  default number of register stages
//   count_width()  bit width needed to hold an occupancy count of 0..depth
//
// Optional feature macro used by the files importing this package:
//   REG_PIPE_FLUSH_EN  adds the synchronous flush_i pipeline clear.
package reg_pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DEPTH = 4;

  // Occupancy ranges over 0..depth inclusive, hence depth+1 codes.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage -- one valid+data register slot of the reg_pipe pipeline.
//
// Ports:
//   clk_i    clock, rising-edge active
//   rst_i    synchronous active-high reset (clears valid and data)
//   flush_i  synchronous valid clear, data kept (only with REG_PIPE_FLUSH_EN)
//   load_i   load enable = this stage is ready this cycle
//   valid_i  valid bit offered by the predecessor (or upstream port)
//   data_i   word offered by the predecessor (or upstream port)
//   valid_o  registered valid bit
//   data_o   registered word
//
// Macro: REG_PIPE_FLUSH_EN adds the flush_i port and its clear logic.
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int unsigned Width = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef REG_PIPE_FLUSH_EN
  input  logic             flush_i,
`endif
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [Width-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = valid_i;
      data_d  = data_i;
    end
`ifdef REG_PIPE_FLUSH_EN
    // A flush drops the slot's contents logically but leaves the data bits
    // untouched, so only the valid bit moves.
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = data_q;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe -- Depth-stage bubble-collapsing register pipeline with
// valid/ready handshakes on both sides.
//
// Handshake: a word moves across a port on a rising edge where that port's
// valid and ready are both 1; valid must not depend on ready, and no other
// cycle moves a word.
//
// Ports:
//   clk_i      clock, rising-edge active
//   rst_i      synchronous active-high reset, overrides every other input
//   flush_i    synchronous clear of all valid bits (only with REG_PIPE_FLUSH_EN)
//   s_valid_i  upstream word valid
//   s_ready_o  pipeline can accept a word this cycle
//   s_data_i   upstream word
//   m_valid_o  last stage holds a valid word (straight from a flop)
//   m_ready_i  downstream accepts the word this cycle
//   m_data_o   word in the last stage (straight from a flop)
//   count_o    number of valid stages
//
// Macro: REG_PIPE_FLUSH_EN adds flush_i; without it no flush logic exists.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int unsigned Width = DEFAULT_WIDTH,
  parameter int unsigned Depth = DEFAULT_DEPTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
`ifdef REG_PIPE_FLUSH_EN
  input  logic                          flush_i,
`endif
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [Width-1:0]              s_data_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [Width-1:0]              m_data_o,
  output logic [count_width(Depth)-1:0] count_o
);

  localparam int unsigned CW = count_width(Depth);

  logic [Depth-1:0] valid_q;
  logic [Width-1:0] data_q [Depth];
  logic [Depth-1:0] ready;

  logic             flush;
  logic             in_xfer;
  logic             out_xfer;
  logic [CW-1:0]    count_q, count_d;

`ifdef REG_PIPE_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Stage k is ready unless it and every stage after it are occupied and
  // the output is stalled. This is the unrolled form of the chain
  // ready[k] = !valid_q[k] | ready[k+1], written per stage so there is no
  // bit-to-bit feedback through a single vector.
  for (genvar k = 0; k < Depth; k++) begin : g_ready
    assign ready[k] = ~(&valid_q[Depth-1:k]) | m_ready_i;
  end

  for (genvar k = 0; k < Depth; k++) begin : g_stage
    logic             in_valid;
    logic [Width-1:0] in_data;

    if (k == 0) begin : g_head
      assign in_valid = s_valid_i;
      assign in_data  = s_data_i;
    end else begin : g_body
      assign in_valid = valid_q[k-1];
      assign in_data  = data_q[k-1];
    end

    reg_pipe_stage #(
      .Width (Width)
    ) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
`ifdef REG_PIPE_FLUSH_EN
      .flush_i (flush_i),
`endif
      .load_i  (ready[k]),
      .valid_i (in_valid),
      .data_i  (in_data),
      .valid_o (valid_q[k]),
      .data_o  (data_q[k])
    );
  end

  // Input is refused during a flush so nothing slips in behind the clear.
  assign s_ready_o = ready[0] & ~flush;
  assign m_valid_o = valid_q[Depth-1];
  assign m_data_o  = data_q[Depth-1];

  assign in_xfer   = s_valid_i & s_ready_o;
  assign out_xfer  = m_valid_o & m_ready_i;

  // Occupancy tracks transfers rather than re-counting valid bits, so it
  // stays a single small adder regardless of Depth.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (in_xfer && !out_xfer) begin
      count_d = count_q + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe -- self-checking bench for reg_pipe (Width=8, Depth=4).
// Define REG_PIPE_FLUSH_EN for both bench and RTL to exercise flush_i.
module tb_reg_pipe;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          s_valid_i = 1'b0;
  logic [W-1:0]  s_data_i = '0;
  logic          m_ready_i = 1'b0;
  logic          s_ready_o;
  logic          m_valid_o;
  logic [W-1:0]  m_data_o;
  logic [CW-1:0] count_o;
`ifdef REG_PIPE_FLUSH_EN
  logic          flush_i = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  reg_pipe #(
    .Width (W),
    .Depth (D)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
`ifdef REG_PIPE_FLUSH_EN
    .flush_i   (flush_i),
`endif
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .count_o   (count_o)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  // The model is a FIFO of accepted words: occupancy is its size, the
  // pipeline refuses input only when all D slots are taken and the output
  // is stalled, and words leave in acceptance order.
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  bit           lat_chk = 1'b0;
  bit           hold_prev = 1'b0;
  logic [W-1:0] hold_data = '0;

  always @(negedge clk) begin : mon
    bit in_x, out_x, flush_now;
    int t;
    flush_now = 1'b0;
`ifdef REG_PIPE_FLUSH_EN
    flush_now = flush_i;
`endif
    if (hold_prev) begin
      chk("hold_valid", m_valid_o, 1);
      chk("hold_data", m_data_o, hold_data);
    end
    chk("s_ready", s_ready_o, !flush_now && !(exp_q.size() == D && !m_ready_i));
    chk("count", count_o, exp_q.size());
    in_x  = s_valid_i && s_ready_o;
    out_x = m_valid_o && m_ready_i;
    if (rst_i) begin
      exp_q.delete();
      acc_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (out_x) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", m_valid_o, 0);
        end else begin
          chk("out_data", m_data_o, exp_q.pop_front());
          t = acc_q.pop_front();
          if (lat_chk) chk("latency", cyc - t, D);
        end
      end
      if (flush_now) begin
        exp_q.delete();
        acc_q.delete();
      end else if (in_x) begin
        exp_q.push_back(s_data_i);
        acc_q.push_back(cyc);
      end
      hold_prev = m_valid_o && !m_ready_i && !flush_now;
      hold_data = m_data_o;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    bit acc;
    s_valid_i = 1'b1;
    s_data_i  = d;
    n = 0;
    forever begin
      @(negedge clk);
      acc = s_ready_o;
      tick();
      if (acc) break;
      n++;
      if (n > 500) begin
        chk("send_timeout", n, 0);
        break;
      end
    end
    s_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  bit rnd_done = 1'b0;

  initial begin
    int c0;
    repeat (3) tick();
    rst_i = 1'b0;
    chk("rst_m_valid", m_valid_o, 0);
    chk("rst_m_data", m_data_o, 0);
    chk("rst_count", count_o, 0);
    tick();
    chk("rst_s_ready", s_ready_o, 1);

    // latency and back-to-back output
    m_ready_i = 1'b1;
    lat_chk   = 1'b1;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    wait_drain();
    lat_chk = 1'b0;

    // fill while stalled, then release
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i));
    s_valid_i = 1'b1;
    s_data_i  = 8'hA4;
    repeat (3) begin
      @(negedge clk);
      chk("full_s_ready", s_ready_o, 0);
      chk("full_count", count_o, 4);
      chk("full_head", m_data_o, 8'hA0);
      tick();
    end
    m_ready_i = 1'b1;
    send(8'hA4);
    send(8'hA5);
    wait_drain();

    // full pipeline streaming: one in, one out per cycle
    m_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(8'hB0 + 8'(i));
    m_ready_i = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      send(8'hC0 + 8'(i));
      chk("thru_count", count_o, 4);
    end
    chk("thru_cycles", cyc - c0, 10);
    wait_drain();

    // reset mid-stream discards in-flight words
    m_ready_i = 1'b0;
    send(8'hD1);
    send(8'hD2);
    s_valid_i = 1'b1;
    s_data_i  = 8'hEE;
    rst_i     = 1'b1;
    tick();
    rst_i     = 1'b0;
    s_valid_i = 1'b0;
    chk("midrst_m_valid", m_valid_o, 0);
    chk("midrst_count", count_o, 0);
    m_ready_i = 1'b1;
    repeat (10) tick();
    chk("midrst_empty", count_o, 0);

`ifdef REG_PIPE_FLUSH_EN
    // flush with a competing input word
    m_ready_i = 1'b0;
    send(8'h01);
    send(8'h02);
    send(8'h03);
    flush_i   = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 8'h55;
    @(negedge clk);
    chk("flush_s_ready", s_ready_o, 0);
    tick();
    flush_i   = 1'b0;
    s_valid_i = 1'b0;
    chk("flush_count", count_o, 0);
    chk("flush_m_valid", m_valid_o, 0);
    m_ready_i = 1'b1;
    repeat (10) tick();
    chk("flush_empty", count_o, 0);
`endif

    // randomized valid/ready traffic
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          while ($urandom_range(1, 0) == 1) tick();
          send(W'($urandom_range(255, 0)));
        end
        rnd_done = 1'b1;
      end
      begin
        int n;
        n = 0;
        while ((!rnd_done || exp_q.size() != 0) && n < 40000) begin
          m_ready_i = ($urandom_range(1, 0) == 1);
          tick();
          n++;
        end
        m_ready_i = 1'b1;
      end
    join
    wait_drain();
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 Parameter Width, default 8, data bits per word (>=1).
REQ-002 Parameter Depth, default 4, number of register stages (>=1).
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 s_valid_i  input  1  upstream word valid.
REQ-006 s_ready_o  output  1  block can accept a word this cycle.
REQ-007 s_data_i  input  Width  upstream word.
REQ-008 m_valid_o  output  1  stage Depth-1 holds a valid word.
REQ-009 m_ready_i  input  1  downstream accepts the word this cycle.
REQ-010 m_data_o  output  Width  word held in stage Depth-1.
REQ-011 count_o  output  $clog2(Depth+1)  number of valid stages.
REQ-012 flush_i  input  1  synchronous pipeline clear; present only with REG_PIPE_FLUSH_EN.

Function
REQ-013 The block SHALL implement Depth stages; stage k holds valid_q[k] and data_q[k]; stage 0 faces input, stage Depth-1 drives m_valid_o/m_data_o directly from flops.
REQ-014 Transfer SHALL occur on a port when valid and ready are both 1 at a rising edge; no other cycle transfers.
REQ-015 Stage Depth-1 ready = !valid_q[Depth-1] | m_ready_i; stage k<Depth-1 ready = !valid_q[k] | ready[k+1] (bubble-collapsing); s_ready_o = ready[0].
REQ-016 A ready stage SHALL load data/valid of its predecessor (stage 0 loads s_data_i/s_valid_i); a non-ready stage SHALL hold data and valid unchanged.
REQ-017 s_ready_o SHALL be combinational from m_ready_i and valid_q only; no combinational path from s_valid_i or s_data_i to any output.
REQ-018 Latency SHALL be exactly Depth cycles from input transfer to m_valid_o=1 when m_ready_i stays 1; throughput one word per cycle.
REQ-019 While m_valid_o=1 and m_ready_i=0, m_data_o SHALL remain stable.
REQ-020 Words SHALL exit in acceptance order; none dropped or duplicated.
REQ-021 Full (all valid, m_ready_i=0): s_ready_o=0; full with m_ready_i=1: s_ready_o=1, simultaneous input and output transfer, count unchanged.
REQ-022 count_o SHALL equal popcount(valid_q), updated each cycle: +1 on input-only transfer, -1 on output-only, unchanged for both or neither.
REQ-023 Depth=1 SHALL behave as a single-entry register with valid/ready, s_ready_o = !m_valid_o | m_ready_i.

Reset
REQ-024 With rst_i=1 at a rising edge, all valid_q, data_q and count_o SHALL become 0; m_valid_o=0, m_data_o=0 the following cycle.
REQ-025 Reset SHALL override every other input, including mid-transfer and flush; in-flight words are discarded.
REQ-026 s_ready_o SHALL be 1 the cycle after reset release.

Configuration
REQ-027 With REG_PIPE_FLUSH_EN defined, flush_i=1 at an edge SHALL clear all valid_q and count_o; data_q retains values; s_ready_o forced 0 during the flush cycle so no input is accepted.
REQ-028 An output transfer in the flush cycle SHALL complete normally (word counted as delivered).
REQ-029 Without REG_PIPE_FLUSH_EN, port flush_i SHALL not exist and all flush logic SHALL be absent.

Structure
REQ-030 Package reg_pipe_pkg SHALL hold default Width/Depth constants and the count-width function.
REQ-031 One stage (valid+data register with load enable = stage ready) SHALL be sub-module reg_pipe_stage, instantiated Depth times via generate.

Verification (Width=8, Depth=4)
REQ-032 Reset, then push 0x11,0x22,0x33 on consecutive cycles, m_ready_i=1 -> 0x11 on m_data_o with m_valid_o=1 exactly 4 cycles after first accept, then 0x22, 0x33 back-to-back.
REQ-033 m_ready_i=0, push 0xA0..0xA5 continuously -> 4 accepted, s_ready_o=0, count_o=4, m_data_o=0xA0 held; raise m_ready_i -> 0xA0..0xA3 in order, then 0xA4, 0xA5.
REQ-034 Full, m_ready_i=1, s_valid_i=1 for 10 cycles -> one in and one out per cycle, count_o stays 4.
REQ-035 Load 2 words, assert rst_i one cycle mid-stream -> m_valid_o=0, count_o=0 next cycle, no stale word later emitted.
REQ-036 With REG_PIPE_FLUSH_EN: 3 words held, m_ready_i=0, flush_i=1 with s_valid_i=1 data 0x55 -> count_o=0, m_valid_o=0, 0x55 not accepted.
REQ-037 Random valid/ready (50%) 1000 words -> output sequence equals input sequence, count_o matches scoreboard every cycle.
